// File: rtl/event_generation.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | event_generation                                                         |
// | Synthesises a pos/neg clock pin pair (single-ended, differential or      |
// | quadrature) with edge strobes aligned to every pin transition.           |
// | Optional: EVENT_GENERATION_BURST_EN adds burst_len_i / burst_done_o.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

package common_p;
    typedef struct packed {
        logic clk;
        logic rst;
    } clk_dom_s;
endpackage

package clks_alot_p;
    typedef struct packed {
        logic pos;
        logic neg;
    } recovery_pins_s;
endpackage

module event_generation #(
    parameter int COUNTER_WIDTH = 16
) (
    input  common_p::clk_dom_s           sys_dom_i,
    input  logic                         generation_en_i,
    input  logic                         source_select_i,
    input  logic [1:0]                   generation_mode_i,
    input  logic [COUNTER_WIDTH-1:0]     phase_cycles_i,
    input  logic                         idle_level_i,
`ifdef EVENT_GENERATION_BURST_EN
    input  logic [COUNTER_WIDTH-1:0]     burst_len_i,
    output logic                         burst_done_o,
`endif
    output clks_alot_p::recovery_pins_s  io_clk_o,
    output logic                         primary_rising_edge_o,
    output logic                         primary_falling_edge_o,
    output logic                         secondary_rising_edge_o,
    output logic                         secondary_falling_edge_o,
    output logic                         period_done_o,
    output logic                         busy_o,
    output logic                         config_err_o
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_DRAIN  = 2'd2;

    localparam logic [1:0] c_MODE_SE   = 2'd0;
    localparam logic [1:0] c_MODE_DIFF = 2'd1;
    localparam logic [1:0] c_MODE_QUAD = 2'd2;
    localparam logic [1:0] c_MODE_RSVD = 2'd3;

    localparam logic [COUNTER_WIDTH-1:0] c_ZERO = '0;
    localparam logic [COUNTER_WIDTH-1:0] c_ONE  = COUNTER_WIDTH'(1);

    logic                     w_clk;
    logic                     w_rst;
    logic [1:0]               r_state;
    logic [1:0]               w_state_next;

    logic [1:0]               r_mode;
    logic [COUNTER_WIDTH-1:0] r_phase;
    logic                     r_src;
    logic                     r_idle;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic [1:0]               r_step;

    logic                     r_pri;
    logic                     r_sec;
    logic                     r_pos;
    logic                     r_neg;
    logic                     r_pri_rise;
    logic                     r_pri_fall;
    logic                     r_sec_rise;
    logic                     r_sec_fall;
    logic                     r_period_done;
    logic                     r_cfg_err;
    logic                     r_err_armed;

    logic                     w_active;
    logic                     w_start_ok;
    logic                     w_start;
    logic                     w_cfg_err;
    logic                     w_step_hit;
    logic                     w_last_step;
    logic                     w_wrap;
    logic                     w_burst_end;
    logic                     w_pri_next;
    logic                     w_sec_next;
    logic                     w_src_next;

    assign w_clk = sys_dom_i.clk;
    assign w_rst = sys_dom_i.rst;

    // Secondary pin level while idle, derived from primary idle level and mode
    function automatic logic idle_sec(input logic [1:0] mode, input logic idle);
        case (mode)
            c_MODE_DIFF: idle_sec = ~idle;
            c_MODE_QUAD: idle_sec = idle;
            default:     idle_sec = 1'b0;
        endcase
    endfunction

    assign w_active    = (r_state != c_ST_IDLE);
    assign w_start     = (r_state == c_ST_IDLE) && generation_en_i &&
                         (generation_mode_i != c_MODE_RSVD) && w_start_ok;
    assign w_cfg_err   = (r_state == c_ST_IDLE) && generation_en_i &&
                         (generation_mode_i == c_MODE_RSVD) && r_err_armed;
    assign w_step_hit  = w_active && (r_count == r_phase);
    assign w_last_step = (r_mode == c_MODE_QUAD) ? (r_step == 2'd3) : (r_step == 2'd1);
    assign w_wrap      = w_step_hit && w_last_step;

`ifdef EVENT_GENERATION_BURST_EN
    logic [COUNTER_WIDTH-1:0] r_burst_len;
    logic [COUNTER_WIDTH-1:0] r_periods;
    logic                     r_burst_lock;
    logic                     r_burst_done;

    assign w_burst_end = w_wrap && (r_burst_len != c_ZERO) &&
                         (r_periods == r_burst_len - c_ONE);
    assign w_start_ok  = ~r_burst_lock;
    assign burst_done_o = r_burst_done;

    // Lock holds off a restart until enable has been dropped after a burst
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_burst_len  <= c_ZERO;
            r_periods    <= c_ZERO;
            r_burst_lock <= 1'b0;
            r_burst_done <= 1'b0;
        end else begin
            r_burst_done <= w_burst_end;
            if (w_start) begin
                r_burst_len <= burst_len_i;
                r_periods   <= c_ZERO;
            end else if (w_wrap) begin
                r_periods   <= r_periods + c_ONE;
            end
            if (w_burst_end)
                r_burst_lock <= 1'b1;
            else if (!generation_en_i)
                r_burst_lock <= 1'b0;
        end
    end
`else
    assign w_burst_end = 1'b0;
    assign w_start_ok  = 1'b1;
`endif

    // State register
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start)
                    w_state_next = c_ST_RUN;
            end
            c_ST_RUN, c_ST_DRAIN: begin
                if (w_wrap && (!generation_en_i || w_burst_end))
                    w_state_next = c_ST_IDLE;
                else if (generation_en_i)
                    w_state_next = c_ST_RUN;
                else
                    w_state_next = c_ST_DRAIN;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // State-derived outputs
    always_comb begin
        busy_o = (r_state == c_ST_RUN) || (r_state == c_ST_DRAIN);
    end

    // Next pin levels: idle levels, fresh start levels, or a step transition
    always_comb begin
        w_pri_next = r_pri;
        w_sec_next = r_sec;
        w_src_next = w_start ? source_select_i : r_src;
        if (w_start) begin
            w_pri_next = idle_level_i;
            w_sec_next = idle_sec(generation_mode_i, idle_level_i);
        end else if (!w_active) begin
            w_pri_next = r_idle;
            w_sec_next = idle_sec(r_mode, r_idle);
        end else if (w_step_hit) begin
            if (r_mode == c_MODE_QUAD) begin
                if (r_step[0])
                    w_sec_next = ~r_sec;
                else
                    w_pri_next = ~r_pri;
            end else begin
                w_pri_next = ~r_pri;
                w_sec_next = (r_mode == c_MODE_DIFF) ? r_pri : 1'b0;
            end
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_mode        <= c_MODE_SE;
            r_phase       <= c_ZERO;
            r_src         <= 1'b0;
            r_idle        <= 1'b0;
            r_count       <= c_ZERO;
            r_step        <= 2'd0;
            r_pri         <= 1'b0;
            r_sec         <= 1'b0;
            r_pos         <= 1'b0;
            r_neg         <= 1'b0;
            r_pri_rise    <= 1'b0;
            r_pri_fall    <= 1'b0;
            r_sec_rise    <= 1'b0;
            r_sec_fall    <= 1'b0;
            r_period_done <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_err_armed   <= 1'b1;
        end else begin
            if (w_start) begin
                r_mode  <= generation_mode_i;
                r_phase <= (phase_cycles_i == c_ZERO) ? c_ONE : phase_cycles_i;
                r_src   <= source_select_i;
                r_idle  <= idle_level_i;
                r_count <= c_ONE;
                r_step  <= 2'd0;
            end else if (w_step_hit) begin
                r_count <= c_ONE;
                r_step  <= w_last_step ? 2'd0 : r_step + 2'd1;
            end else if (w_active) begin
                r_count <= r_count + c_ONE;
            end else begin
                r_count <= c_ZERO;
                r_step  <= 2'd0;
            end

            r_pri         <= w_pri_next;
            r_sec         <= w_sec_next;
            r_pos         <= w_src_next ? w_pri_next : w_sec_next;
            r_neg         <= w_src_next ? w_sec_next : w_pri_next;
            r_pri_rise    <= w_pri_next & ~r_pri;
            r_pri_fall    <= ~w_pri_next & r_pri;
            r_sec_rise    <= w_sec_next & ~r_sec;
            r_sec_fall    <= ~w_sec_next & r_sec;
            r_period_done <= w_wrap;
            r_cfg_err     <= w_cfg_err;

            if (!generation_en_i)
                r_err_armed <= 1'b1;
            else if (w_cfg_err)
                r_err_armed <= 1'b0;
        end
    end

    assign io_clk_o.pos             = r_pos;
    assign io_clk_o.neg             = r_neg;
    assign primary_rising_edge_o    = r_pri_rise;
    assign primary_falling_edge_o   = r_pri_fall;
    assign secondary_rising_edge_o  = r_sec_rise;
    assign secondary_falling_edge_o = r_sec_fall;
    assign period_done_o            = r_period_done;
    assign config_err_o             = r_cfg_err;

endmodule

`default_nettype wire
